// File: rtl/array_reduce.sv
// rtl/array_reduce.sv - streaming sum/max/min/prefix-sum reduction over a two-port RAM
module array_reduce #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              finish,
    output logic              busy,
    input  logic [ADDR_W-1:0] n,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] res,
    output logic              arr_clk,
    output logic              arr_read_en,
    output logic [ADDR_W-1:0] arr_read_addr,
    input  logic [DATA_W-1:0] arr_read_val,
    output logic              arr_write_en,
    output logic [ADDR_W-1:0] arr_write_addr,
    output logic [DATA_W-1:0] arr_write_val
);
    localparam int CW = ADDR_W + $clog2(RD_LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_n;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [1:0]        r_op;
    logic [CW-1:0]     r_cyc;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_res;
    logic [RD_LAT-1:0] r_vld;
    logic [ADDR_W-1:0] r_idx [RD_LAT];
    logic [DATA_W-1:0] w_acc_nxt;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_ident;
    logic              w_rd_en;
    logic              w_ret_vld;
    logic              w_last;

    assign w_rd_en   = (r_state == RUN) && (r_rd_cnt < r_n);
    assign w_ret_vld = r_vld[RD_LAT-1];
    assign w_sum     = r_acc + arr_read_val;
    // RUN lasts n+RD_LAT cycles, so n=0 still waits out the read latency
    assign w_last    = (r_state == RUN) && (r_cyc == CW'(r_n) + CW'(RD_LAT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (op)
            2'd1:    w_ident = {1'b1, {(DATA_W-1){1'b0}}};
            2'd2:    w_ident = {1'b0, {(DATA_W-1){1'b1}}};
            default: w_ident = '0;
        endcase
    end

    always_comb begin
        w_acc_nxt = r_acc;
        if (w_ret_vld) begin
            case (r_op)
                2'd1:    if ($signed(arr_read_val) > $signed(r_acc)) w_acc_nxt = arr_read_val;
                2'd2:    if ($signed(arr_read_val) < $signed(r_acc)) w_acc_nxt = arr_read_val;
                default: w_acc_nxt = w_sum;
            endcase
        end
    end

    // Valid/index tags travel alongside the RAM read pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) r_idx[i] <= '0;
        end else begin
            r_vld[0] <= w_rd_en;
            r_idx[0] <= r_rd_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n      <= '0;
            r_op     <= '0;
            r_rd_cnt <= '0;
            r_cyc    <= '0;
            r_acc    <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n      <= n;
                        r_op     <= op;
                        r_acc    <= w_ident;
                        r_rd_cnt <= '0;
                        r_cyc    <= '0;
                    end
                end
                RUN: begin
                    if (w_rd_en) r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
                    r_cyc <= r_cyc + CW'(1);
                    r_acc <= w_acc_nxt;
                    if (w_last) r_res <= w_acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign finish         = (r_state == DONE);
    assign busy           = (r_state != IDLE);
    assign res            = r_res;
    assign arr_clk        = clk;
    assign arr_read_en    = w_rd_en;
    assign arr_read_addr  = w_rd_en ? r_rd_cnt : '0;
    assign arr_write_en   = w_ret_vld && (r_op == 2'd3);
    assign arr_write_addr = arr_write_en ? r_idx[RD_LAT-1] : '0;
    assign arr_write_val  = arr_write_en ? w_sum : '0;
endmodule
